// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the request-master state set.
package axil_pkg;

    // AXI4-Lite BRESP/RRESP encodings
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    // Request-master FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } axil_mst_state_e;

endpackage

// File: rtl/axilite_req_master.sv
// Single-outstanding AXI4-Lite master: converts a valid/ready register-access
// request stream into AXI4-Lite transactions and returns one response per request.
module axilite_req_master
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    // request stream
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    // response stream
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_we,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ERR_CNT_W-1:0]      err_cnt,
    // write address channel
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    // write data channel
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WVALID,
    input  logic                      WREADY,
    // write response channel
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,
    // read address channel
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    // read data channel
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RVALID,
    output logic                      RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;

    // registered state
    axil_mst_state_e         r_state;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic                    r_rsp_valid;
    logic                    r_rsp_we;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]              r_rsp_resp;
    logic [ERR_CNT_W-1:0]    r_err_cnt;

    // next-state values
    axil_mst_state_e         w_state_nxt;
    logic                    w_aw_done_nxt;
    logic                    w_w_done_nxt;
    logic                    w_awvalid_nxt;
    logic                    w_wvalid_nxt;
    logic                    w_bready_nxt;
    logic                    w_arvalid_nxt;
    logic                    w_rready_nxt;
    logic [ADDR_WIDTH-1:0]   w_awaddr_nxt;
    logic [ADDR_WIDTH-1:0]   w_araddr_nxt;
    logic [DATA_WIDTH-1:0]   w_wdata_nxt;
    logic [STRB_W-1:0]       w_wstrb_nxt;
    logic                    w_rsp_valid_nxt;
    logic                    w_rsp_we_nxt;
    logic [DATA_WIDTH-1:0]   w_rsp_rdata_nxt;
    logic [1:0]              w_rsp_resp_nxt;
    logic [ERR_CNT_W-1:0]    w_err_cnt_nxt;
    logic                    w_rsp_latch;

    // channel handshakes seen this cycle
    logic w_req_hs;
    logic w_aw_hs;
    logic w_w_hs;

    assign w_req_hs = req_valid && (r_state == IDLE);
    assign w_aw_hs  = r_awvalid && AWREADY;
    assign w_w_hs   = r_wvalid && WREADY;

    // Next-state and next-output computation for the transaction FSM
    always_comb begin
        // NOTE: every next value defaults to its current register first, so no path can infer a latch.
        w_state_nxt     = r_state;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_awaddr_nxt    = r_awaddr;
        w_araddr_nxt    = r_araddr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_we_nxt    = r_rsp_we;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_err_cnt_nxt   = r_err_cnt;
        w_rsp_latch     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req_hs) begin
                    w_rsp_we_nxt = req_we;
                    if (req_we) begin
                        w_state_nxt   = WR_AW_W;
                        w_awaddr_nxt  = req_addr;
                        w_wdata_nxt   = req_wdata;
                        w_wstrb_nxt   = req_wstrb;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                    end else begin
                        w_state_nxt   = RD_ADDR;
                        w_araddr_nxt  = req_addr;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                // AW and W retire independently; each VALID drops after its own handshake
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt  = WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_resp_nxt  = BRESP;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_latch     = 1'b1;
                    w_state_nxt     = RSP;
                end
            end
            RD_ADDR: begin
                if (ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_resp_nxt  = RRESP;
                    w_rsp_rdata_nxt = RDATA;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_latch     = 1'b1;
                    w_state_nxt     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // saturating count of non-OKAY responses
        if (w_rsp_latch && (w_rsp_resp_nxt != OKAY) && (r_err_cnt != '1)) begin
            w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge ACLK) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values together.
        if (ARESET) begin
            r_state     <= IDLE;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_araddr    <= w_araddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_we    <= w_rsp_we_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_we    = r_rsp_we;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign err_cnt   = r_err_cnt;
    assign AWADDR    = r_awaddr;
    assign AWVALID   = r_awvalid;
    assign WDATA     = r_wdata;
    assign WSTRB     = r_wstrb;
    assign WVALID    = r_wvalid;
    assign BREADY    = r_bready;
    assign ARADDR    = r_araddr;
    assign ARVALID   = r_arvalid;
    assign RREADY    = r_rready;

endmodule

// File: tb/tb_axilite_req_master.sv
// Bench for axilite_req_master: behavioural 32-word AXI4-Lite slave with
// programmable READY delays, reference memory and an in-order response scoreboard.
module tb_axilite_req_master;

    logic        ACLK;
    logic        ARESET;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [2:0]  err_cnt;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    // A 3-bit error counter keeps saturation reachable in a few transactions
    axilite_req_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ERR_CNT_W(3)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_cnt(err_cnt),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        logic [1:0]  resp;
        bit          chk_lat;
        int          hs_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [32];
    logic [31:0] smem    [32];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_err = 0;
    int proto_err = 0;
    int b_hs_cnt = 0;
    int last_req_hs_cyc = 0;
    int aw_dly = 0, w_dly = 0, ar_dly = 0;
    bit bp_done = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        forever begin
            @(posedge ACLK);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500us");
        $fatal(1);
    end

    // Behavioural slave: decides READY/VALID at each negedge for the coming posedge
    initial begin
        logic        aw_got, w_got, ar_got, b_fire, r_fire;
        logic        aw_wait, w_wait, ar_wait, aw_hs_prev, w_hs_prev, ar_hs_prev;
        int          aw_cnt, w_cnt, ar_cnt;
        logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
        logic [3:0]  w_strb_q;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; aw_hs_prev = 0; w_hs_prev = 0; ar_hs_prev = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_addr_q = 0; w_data_q = 0; ar_addr_q = 0; w_strb_q = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        for (int i = 0; i < 32; i++) smem[i] = 32'h0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
                aw_hs_prev = 0; w_hs_prev = 0; ar_hs_prev = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_hs_cnt = 0;
            end else begin
                // VALID must stay up until its handshake, and drop right after it
                if (aw_wait && !AWVALID) proto_err++;
                if (w_wait && !WVALID) proto_err++;
                if (ar_wait && !ARVALID) proto_err++;
                if (aw_hs_prev) check("awvalid_drop", 64'(AWVALID), 64'(0));
                if (w_hs_prev) check("wvalid_drop", 64'(WVALID), 64'(0));
                if (ar_hs_prev) check("arvalid_drop", 64'(ARVALID), 64'(0));
                aw_hs_prev = 0; w_hs_prev = 0; ar_hs_prev = 0;

                // B channel
                if (b_fire) begin BVALID = 0; b_fire = 0; end
                if (!BVALID && aw_got && w_got) begin
                    if (aw_addr_q < 32'd128) begin
                        for (int b = 0; b < 4; b++)
                            if (w_strb_q[b]) smem[aw_addr_q[6:2]][8*b +: 8] = w_data_q[8*b +: 8];
                        BRESP = 2'b00;
                    end else begin
                        BRESP = 2'b10;
                    end
                    BVALID = 1; aw_got = 0; w_got = 0;
                end
                if (BVALID && BREADY) begin b_fire = 1; b_hs_cnt++; end

                // R channel
                if (r_fire) begin RVALID = 0; r_fire = 0; end
                if (!RVALID && ar_got) begin
                    if (ar_addr_q < 32'd128) begin RDATA = smem[ar_addr_q[6:2]]; RRESP = 2'b00; end
                    else begin RDATA = 32'h0; RRESP = 2'b10; end
                    RVALID = 1; ar_got = 0;
                end
                if (RVALID && RREADY) r_fire = 1;

                // AW / W / AR ready with per-channel delays
                AWREADY = 0; WREADY = 0; ARREADY = 0;
                if (AWVALID && !aw_got) begin
                    if (aw_cnt >= aw_dly) begin
                        AWREADY = 1; aw_got = 1; aw_hs_prev = 1; aw_cnt = 0; aw_addr_q = AWADDR;
                    end else aw_cnt++;
                end
                if (WVALID && !w_got) begin
                    if (w_cnt >= w_dly) begin
                        WREADY = 1; w_got = 1; w_hs_prev = 1; w_cnt = 0;
                        w_data_q = WDATA; w_strb_q = WSTRB;
                    end else w_cnt++;
                end
                if (ARVALID && !ar_got && !RVALID) begin
                    if (ar_cnt >= ar_dly) begin
                        ARREADY = 1; ar_got = 1; ar_hs_prev = 1; ar_cnt = 0; ar_addr_q = ARADDR;
                    end else ar_cnt++;
                end
                aw_wait = AWVALID && !AWREADY && !aw_got;
                w_wait  = WVALID && !WREADY && !w_got;
                ar_wait = ARVALID && !ARREADY && !ar_hs_prev;
            end
        end
    end

    // Response monitor: pops the scoreboard on every response handshake
    initial begin
        exp_t e;
        bit   seen;
        int   first_cyc;
        seen = 0; first_cyc = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                seen = 0;
            end else begin
                if (rsp_valid && !seen) begin seen = 1; first_cyc = cyc; end
                if (rsp_valid && rsp_ready) begin
                    seen = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 64'(sb.size()), 64'(1));
                    end else begin
                        e = sb.pop_front();
                        check("rsp_we", 64'(rsp_we), 64'(e.we));
                        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                        if (e.chk_lat) check("latency", 64'(first_cyc - e.hs_cyc), 64'(3));
                        if (e.resp != 2'b00 && exp_err != 7) exp_err++;
                        check("err_cnt", 64'(err_cnt), 64'(exp_err));
                        check("b_accepts", 64'(b_hs_cnt), 64'(e.we));
                        b_hs_cnt = 0;
                    end
                end
            end
        end
    end

    // Issue one request, compute its expected response and push it at handshake
    task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit lat);
        exp_t e;
        bit   ok;
        e.we = we; e.chk_lat = lat; e.hs_cyc = 0;
        if (we) begin
            e.rdata = 32'h0;
            if (addr < 32'd128) begin
                e.resp = 2'b00;
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[addr[6:2]][8*b +: 8] = data[8*b +: 8];
            end else e.resp = 2'b10;
        end else begin
            if (addr < 32'd128) begin e.rdata = ref_mem[addr[6:2]]; e.resp = 2'b00; end
            else begin e.rdata = 32'h0; e.resp = 2'b10; end
        end
        req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb; req_valid = 1;
        ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge ACLK);
            if (req_ready) ok = 1;
        end
        if (ok) begin
            e.hs_cyc = cyc; last_req_hs_cyc = cyc;
            sb.push_back(e);
            @(posedge ACLK);
            #1;
        end else begin
            check("req_accept_timeout", 64'(req_ready), 64'(1));
        end
        req_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge ACLK);
        check("drain", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        ARESET = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        rsp_ready = 1;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 0;

        // reset state
        @(negedge ACLK);
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_valids", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_fields", 64'({rsp_we, rsp_resp, rsp_rdata}), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_addr", 64'({AWADDR, ARADDR}), 64'(0));
        @(posedge ACLK); #1;

        // full-word write/read with zero-wait latency
        send_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 1); drain();
        send_req(0, 32'h10, 32'h0, 4'h0, 1);        drain();
        // partial strobe
        send_req(1, 32'h10, 32'h00001234, 4'h3, 1); drain();
        send_req(0, 32'h10, 32'h0, 4'h0, 0);        drain();
        // out-of-range read
        send_req(0, 32'h80, 32'h0, 4'h0, 1);        drain();

        // AW/W ordering: W first, AW first, both together (last one errors via B)
        aw_dly = 3; w_dly = 0; send_req(1, 32'h20, 32'hA5A50001, 4'hF, 0); drain();
        aw_dly = 0; w_dly = 3; send_req(1, 32'h24, 32'h5A5A0002, 4'hF, 0); drain();
        aw_dly = 2; w_dly = 2; send_req(1, 32'h84, 32'h11112222, 4'hF, 0); drain();
        aw_dly = 0; w_dly = 0;
        send_req(0, 32'h20, 32'h0, 4'h0, 0); drain();
        ar_dly = 3; send_req(0, 32'h24, 32'h0, 4'h0, 0); drain(); ar_dly = 0;

        // saturation of the error counter
        for (int i = 0; i < 6; i++) begin
            send_req(0, 32'h80 + 32'(4 * i), 32'h0, 4'h0, 0); drain();
        end
        @(negedge ACLK);
        check("err_saturated", 64'(err_cnt), 64'(7));
        @(posedge ACLK); #1;

        // response back-pressure with a pending request
        rsp_ready = 0;
        send_req(1, 32'h28, 32'h0BADF00D, 4'hF, 0);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge ACLK);
        fork
            begin
                send_req(0, 32'h28, 32'h0, 4'h0, 0);
                bp_done = 1;
            end
        join_none
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            check("bp_rsp_fields", 64'({rsp_we, rsp_resp, rsp_rdata}), 64'({1'b1, 2'b00, 32'h0}));
            check("bp_req_ready", 64'(req_ready), 64'(0));
        end
        @(posedge ACLK); #1 rsp_ready = 1;
        @(negedge ACLK);
        begin
            int rsp_hs_c;
            rsp_hs_c = cyc;
            for (int i = 0; i < 50 && !bp_done; i++) @(negedge ACLK);
            check("bp_req_done", 64'(bp_done), 64'(1));
            check("bp_req_next_cycle", 64'(last_req_hs_cyc), 64'(rsp_hs_c + 1));
        end
        drain();

        // reset while in WR_AW_W with AWVALID high
        aw_dly = 20; w_dly = 20;
        send_req(1, 32'h2C, 32'hCAFE0003, 4'hF, 0);
        @(negedge ACLK);
        check("pre_rst_awvalid", 64'(AWVALID), 64'(1));
        @(posedge ACLK); #1 ARESET = 1;
        @(posedge ACLK); #1 ARESET = 0;
        sb.delete(); exp_err = 0;
        for (int b = 0; b < 4; b++) ref_mem[11][8*b +: 8] = 8'h0;
        @(negedge ACLK);
        check("mid_rst_valids", 64'({AWVALID, WVALID, ARVALID}), 64'(0));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready), 64'(1));
        check("mid_rst_err_cnt", 64'(err_cnt), 64'(0));
        @(posedge ACLK); #1;
        aw_dly = 0; w_dly = 0;
        repeat (3) @(negedge ACLK);
        check("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
        @(posedge ACLK); #1;

        // recovery after reset
        send_req(1, 32'h2C, 32'h13572468, 4'hF, 1); drain();
        send_req(0, 32'h2C, 32'h0, 4'h0, 1);        drain();

        check("protocol_violations", 64'(proto_err), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
